// File: rtl/mig_bist_pkg.sv
// Shared types, polynomials and next-state helpers for the majority-chain BIST controller.
package mig_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int              LFSR_W       = 13;
  localparam int              MISR_W       = 16;
  // Tap mask for x^13+x^4+x^3+x+1: bits 12,3,2,0 feed the shift-in bit.
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 13'h100D;
  localparam logic [MISR_W-1:0] MISR_POLY  = 16'h1021;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 13'h0001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic            bit_in);
    logic fb;
    fb = sig[MISR_W-1] ^ bit_in;
    return {sig[MISR_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
  endfunction

endpackage

// File: rtl/mig_bist_ctrl_if.sv
// Handshake and data bundle between the BIST controller and its requester / chain under test.
interface mig_bist_ctrl_if #(
  parameter int PI_W  = 13,
  parameter int SIG_W = 16
);
  logic             start;
  logic [SIG_W-1:0] golden;
  logic [PI_W-1:0]  pi_out;
  logic             po_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [15:0]      pat_count;

  modport master (
    output start, golden, po_in,
    input  pi_out, busy, done, pass, signature, pat_count
  );

  modport slave (
    input  start, golden, po_in,
    output pi_out, busy, done, pass, signature, pat_count
  );
endinterface

// File: rtl/mig_bist_lfsr.sv
// Pattern register: loads the seed on a run start and advances one LFSR step per absorb.
module mig_bist_lfsr
  import mig_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [LFSR_W-1:0] q_o
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)     q_d = SEED;
    else if (adv_i) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mig_bist_ctrl.sv
// BIST sequencer: drives LFSR patterns into the chain, compacts po_in into a MISR, grades vs golden.
module mig_bist_ctrl
  import mig_bist_pkg::*;
#(
  parameter int                PI_W       = 13,
  parameter int                SIG_W      = 16,
  parameter int                N_PATTERNS = 1023,
  parameter int                SETTLE     = 0,
  parameter logic [PI_W-1:0]   LFSR_SEED  = DEFAULT_SEED
) (
  input logic            clk,
  input logic            rst_n,
  mig_bist_ctrl_if.slave bus
);

  localparam int SET_W = 4;

  state_e           state_q;
  logic [SIG_W-1:0] sig_q, sig_d, gold_q;
  logic [15:0]      cnt_q;
  logic [SET_W-1:0] settle_q;
  logic             busy_q, done_q, pass_q;
  logic             load, absorb;
  logic [PI_W-1:0]  pi_q;

  assign load   = bus.start && (state_q != ST_RUN);
  assign absorb = (state_q == ST_RUN) && (settle_q == SET_W'(SETTLE));
  assign sig_d  = misr_next(sig_q, bus.po_in);

  mig_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .adv_i  (absorb),
    .q_o    (pi_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sig_q    <= '0;
      gold_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!absorb) begin
            settle_q <= settle_q + 1'b1;
          end else begin
            settle_q <= '0;
            sig_q    <= sig_d;
            cnt_q    <= cnt_q + 16'd1;
            // Grade against the signature being written this edge, not the stale one.
            if (cnt_q == 16'(N_PATTERNS - 1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == gold_q);
            end
          end
        end
        default: begin
          if (bus.start) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            gold_q   <= bus.golden;
          end
        end
      endcase
    end
  end

  assign bus.pi_out    = pi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.pat_count = cnt_q;

endmodule

// File: doc/mig_bist_ctrl.md
# mig_bist_ctrl

Built-in self-test controller for the synthetic majority-gate benchmark netlists. It drives the 13 primary inputs of a combinational majority-chain block with LFSR pseudo-random patterns and compacts the single primary output into a CRC-style signature. At the end of a run it compares the signature against a golden value. It sits directly upstream of the chain (feeding `pi*`) and directly downstream of it (consuming `po0`).

## Interface
Parameters:
- `PI_W`, 13, pattern width; equals the DUT primary-input count.
- `SIG_W`, 16, signature width.
- `N_PATTERNS`, 1023, patterns per run; legal range 1..2^16-1.
- `SETTLE`, 0, extra hold cycles per pattern before `po_in` is sampled; legal range 0..15.
- `LFSR_SEED`, 13'h0001, initial pattern; must be non-zero.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a run.
- `golden` in SIG_W: expected signature; sampled when `start` is accepted.
- `pi_out` out PI_W: pattern to DUT, `pi_out[k]` drives `pi<k>`; registered.
- `po_in` in 1: DUT `po0`; combinational path from `pi_out`.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: signature equals the latched golden value; valid only while `done` is high.
- `signature` out SIG_W: current MISR contents.
- `pat_count` out 16: number of patterns absorbed so far.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: `pi_out`=0, `signature`=0, `pat_count`=0, `busy`=0, `done`=0, `pass`=0, latched golden=0.
- IDLE/DONE + `start`=1:
  - Go to RUN.
  - `pi_out` ← LFSR_SEED; signature ← 0; `pat_count` ← 0; settle counter ← 0.
  - Latch `golden`.
  - `pass` clears on leaving DONE.
- RUN, each cycle:
  - If settle counter < SETTLE: increment it.
  - Otherwise absorb: MISR shifts in `po_in`, LFSR advances, `pat_count`++, settle counter ← 0.
- LFSR (Fibonacci, x^13+x^4+x^3+x+1): next = {q[11:0], q[12]^q[3]^q[2]^q[0]}. Period is 8191, so it never reaches 0.
- MISR (serial CRC, poly 0x1021): fb = sig[15]^po_in; next = {sig[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- Completion: an absorb with `pat_count`==N_PATTERNS-1 moves to DONE.
  - `pass` ← (next signature == latched golden).
  - `pi_out` holds the last advanced value.
- DONE: outputs hold until `start` arrives (restart) or reset.
- `start` while in RUN is ignored; the run is not restarted.
- Reset mid-run: immediate return to IDLE with all reset values; no partial result is kept.
- `pat_count` never wraps, because N_PATTERNS is bounded below 2^16.

## Timing
- `start` sampled at edge T: `busy`=1 and `pi_out`=seed after T.
- Pattern i is presented for SETTLE+1 cycles. `po_in` is sampled at the last edge of that window.
- `done` rises after edge T+N_PATTERNS*(SETTLE+1). With defaults this is T+1023.
- `done` and `busy` are never high together. In the DONE cycle `busy` falls and `done` rises on the same edge.
- `pass`, `signature` and `done` all update on the same edge.
- `start` in DONE: `done` falls one cycle later, together with the reload.

## Structure
- Package `mig_bist_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - localparams LFSR_TAPS and MISR_POLY (16'h1021);
  - the default seed;
  - pure functions `lfsr_next` and `misr_next`.
- One sub-module, `mig_bist_lfsr`: the pattern register with load and advance enables.
- MISR, counters and FSM live in the top module.

## Test plan
- Reset mid-run (assert `rst_n`=0 at cycle 50) → every output returns to its reset value. A following `start` runs a full sequence from the seed.
- Pattern sequence, defaults → after `start`, `pi_out` reads 0x0001, 0x0003, 0x0007, 0x000E on successive cycles.
- Model DUT with `po_in`≡0, N_PATTERNS=1023, `golden`=0 → `done` at T+1023, `signature`=0x0000, `pass`=1, `pat_count`=1023.
- Model DUT with `po_in`≡1:
  - N_PATTERNS=1, `golden`=0x1021 → `pass`=1.
  - N_PATTERNS=2, `golden`=0x1021 → `signature`=0x3063, `pass`=0.
- SETTLE=3, N_PATTERNS=4 → each `pi_out` value is held for 4 cycles; `done` at T+16.
- `start` pulsed again at cycle T+10 during RUN → ignored; completion timing is unchanged. `start` in DONE → clean restart with `pass` cleared.
- Real majority-chain netlist against a golden signature from the reference model → `pass`=1. The same run with one chain gate inverted → `pass`=0.
